imem_dmem_arbiter: RTL and testbench
====================================

Name: imem_dmem_arbiter

Overview:
- Shares one single-port memory between the instruction-fetch requester (IF stage) and the data requester (MEM stage: loads/stores).
- Sequences each access: arbitrate, issue, wait the fixed memory latency, return data.
- Produces per-requester stall signals that feed the pipeline hazard logic.
- Supports fetch flush on branch redirect and bounds fetch starvation.

Parameters:
MEM_LAT, 2, cycles from the mem_en cycle to valid mem_rdata; legal range 1..15
STARVE_MAX, 4, max consecutive data grants while if_req is pending before fetch is forced; legal range 1..15

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset (rst=0 resets)
if_req  in  1  fetch request; held high with if_addr stable until if_valid
if_addr  in  32  fetch byte address
if_flush  in  1  branch redirect; kills the pending fetch
if_rdata  out  32  fetched instruction
if_valid  out  1  one-cycle pulse: if_rdata valid
if_stall  out  1  if_req & ~if_valid
d_req  in  1  data request; held high with d_we/d_addr/d_wdata stable until d_valid
d_we  in  1  1=store, 0=load
d_addr  in  32  data byte address
d_wdata  in  32  store data
d_rdata  out  32  load data
d_valid  out  1  one-cycle pulse: access complete (load data valid or store done)
d_stall  out  1  d_req & ~d_valid
mem_en  out  1  memory access strobe, one cycle per access
mem_we  out  1  write enable, qualified by mem_en
mem_addr  out  32  memory byte address
mem_wdata  out  32  memory write data
mem_rdata  in  32  memory read data, valid MEM_LAT cycles after the mem_en cycle

Behaviour:
- Reset (rst=0, any time, asynchronous):
  - state=IDLE; owner, latched addr/we/wdata, cnt, streak, kill flag, if_rdata and d_rdata all cleared to 0.
  - All outputs 0.
  - An in-flight access is abandoned; no valid is produced for it.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - Samples requests. A fetch request is eligible when if_req=1 and if_flush=0.
  - Fetch eligible only: grant IF.
  - d_req only: grant D.
  - Both present: grant IF if streak==STARVE_MAX, otherwise grant D.
  - On grant: latch owner, addr, we (forced 0 for IF) and wdata; go to ISSUE.
  - No request: stay in IDLE.
- ISSUE (1 cycle):
  - Drive mem_en=1 and mem_we/mem_addr/mem_wdata from the latches.
  - cnt<=1; go to WAIT.
  - mem_en=0 in every other state; mem_addr/mem_wdata hold their latched values.
- WAIT:
  - While cnt<MEM_LAT: cnt<=cnt+1.
  - When cnt==MEM_LAT: capture mem_rdata into the owner's rdata register (D writes do not update d_rdata); go to DONE.
- DONE (1 cycle):
  - Assert the owner's valid, unless owner is IF and the kill flag is set.
  - Go to IDLE.
  - Non-owner rdata holds its last value.
- Timing:
  - Request sampled in cycle 0 → valid in cycle MEM_LAT+2.
  - Next grant decision in cycle MEM_LAT+3.
  - Sustained throughput: one access per MEM_LAT+3 cycles.
- Flush:
  - if_flush in IDLE suppresses fetch eligibility that cycle.
  - if_flush while owner=IF in ISSUE/WAIT/DONE sets the kill flag. The memory access still completes, but if_valid stays 0 and if_rdata is not updated.
  - Kill flag clears on return to IDLE.
  - if_flush has no effect on a D transaction.
- Starvation counter (streak, saturating at STARVE_MAX):
  - On a D grant: increments if if_req=1, otherwise resets to 0.
  - On an IF grant: resets to 0.
- Requester protocol:
  - Requests are not retracted before their valid.
  - Dropping req mid-transaction does not abort the access.
  - Stall outputs are combinational from req and valid.

Test Plan:
- Reset, then if_req=1, if_addr=0x40, MEM_LAT=2, memory returns 0x8C220004 → mem_en=1 with mem_addr=0x40 in cycle 1; if_valid=1 with if_rdata=0x8C220004 in cycle 4; if_stall=1 in cycles 0–3 and 0 in cycle 4.
- if_req and d_req both held high continuously, STARVE_MAX=4 → grant order D,D,D,D,IF,D,D,D,D,IF; d_valid and if_valid never coincide.
- Store: d_req=1, d_we=1, d_addr=0x100, d_wdata=0xDEADBEEF → exactly one mem_en cycle with mem_we=1, addr 0x100, data 0xDEADBEEF; d_valid pulses in cycle 4; d_rdata unchanged.
- IF granted, then if_flush=1 in WAIT → mem_en still pulses once, if_valid stays 0, if_rdata keeps its old value, FSM is back in IDLE in cycle 5.
- Assert rst=0 asynchronously mid-WAIT → all outputs 0 immediately; after release, the re-presented request is served with fresh latency (valid at MEM_LAT+2).
- MEM_LAT=1 and MEM_LAT=15 sweeps with back-to-back IF requests → period is exactly 4 and 18 cycles respectively.

Source files
------------

// File: rtl/imem_dmem_arbiter_if.sv
// Requester and memory bus signals of the IF/MEM single-port memory arbiter.
// The master modport is the arbiter side; slave is the requester/memory side.
interface imem_dmem_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_flush;
    logic [31:0] if_rdata;
    logic        if_valid;
    logic        if_stall;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_valid;
    logic        d_stall;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport master (
        input  if_req, if_addr, if_flush,
        output if_rdata, if_valid, if_stall,
        input  d_req, d_we, d_addr, d_wdata,
        output d_rdata, d_valid, d_stall,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport slave (
        output if_req, if_addr, if_flush,
        input  if_rdata, if_valid, if_stall,
        output d_req, d_we, d_addr, d_wdata,
        input  d_rdata, d_valid, d_stall,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/imem_dmem_arbiter.sv
// Shares one single-port memory between instruction fetch and data access,
// with fixed-latency sequencing, fetch flush and bounded fetch starvation.
module imem_dmem_arbiter #(
    parameter int unsigned MEM_LAT    = 2,
    parameter int unsigned STARVE_MAX = 4
) (
    input logic                 clk,
    input logic                 rst,
    imem_dmem_arbiter_if.master bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    localparam logic [3:0] LAT  = 4'(MEM_LAT);
    localparam logic [3:0] SMAX = 4'(STARVE_MAX);

    state_t      state;
    state_t      state_nxt;
    logic        owner;
    logic        we;
    logic        kill;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] if_rdata;
    logic [31:0] d_rdata;
    logic [3:0]  cnt;
    logic [3:0]  streak;
    logic        if_elig;
    logic        grant_if;
    logic        grant_d;
    logic        last;

    // Grant decision in IDLE: fetch wins only when alone or when starved.
    always_comb begin
        if_elig  = bus.if_req & ~bus.if_flush;
        grant_if = (state == IDLE) & if_elig & (~bus.d_req | (streak == SMAX));
        grant_d  = (state == IDLE) & bus.d_req & ~grant_if;
        last     = (state == WAIT) & (cnt == LAT);
    end

    // Next-state sequencing: arbitrate, issue, wait latency, return.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (grant_if | grant_d) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Transaction latches, latency counter, starvation streak, kill flag and read data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner    <= 1'b0;
            we       <= 1'b0;
            addr     <= '0;
            wdata    <= '0;
            cnt      <= '0;
            streak   <= '0;
            kill     <= 1'b0;
            if_rdata <= '0;
            d_rdata  <= '0;
        end else begin
            if (grant_if | grant_d) begin
                owner <= grant_d;
                we    <= grant_d & bus.d_we;
                addr  <= grant_d ? bus.d_addr : bus.if_addr;
                wdata <= grant_d ? bus.d_wdata : '0;
            end
            if (state == ISSUE)
                cnt <= 4'd1;
            else if (state == WAIT && cnt < LAT)
                cnt <= cnt + 4'd1;
            if (grant_if)
                streak <= '0;
            else if (grant_d)
                streak <= !bus.if_req ? '0 : (streak == SMAX) ? SMAX : streak + 4'd1;
            if (state == DONE)
                kill <= 1'b0;
            else if (state != IDLE && !owner && bus.if_flush)
                kill <= 1'b1;
            if (last && !owner && !kill && !bus.if_flush)
                if_rdata <= bus.mem_rdata;
            if (last && owner && !we)
                d_rdata <= bus.mem_rdata;
        end
    end

    // Memory strobe only in ISSUE; address and data hold their latched values.
    always_comb begin
        bus.mem_en    = (state == ISSUE);
        bus.mem_we    = (state == ISSUE) & we;
        bus.mem_addr  = addr;
        bus.mem_wdata = wdata;
        bus.if_rdata  = if_rdata;
        bus.d_rdata   = d_rdata;
        bus.if_valid  = (state == DONE) & ~owner & ~kill;
        bus.d_valid   = (state == DONE) & owner;
        bus.if_stall  = rst & bus.if_req & ~bus.if_valid;
        bus.d_stall   = rst & bus.d_req & ~bus.d_valid;
    end
endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Scoreboard bench for imem_dmem_arbiter: main instance (MEM_LAT=2) plus
// MEM_LAT=1 and MEM_LAT=15 instances streaming back-to-back fetches.
module tb_imem_dmem_arbiter;
    typedef struct {
        logic [31:0] data;
        int          cyc;
    } rsp_t;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        int          cyc;
    } acc_t;

    localparam logic [31:0] SWA = 32'h0000_2000;

    logic clk = 1'b0;
    logic rst;
    logic rst_sw;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    logic        if_req   [3];
    logic [31:0] if_addr  [3];
    logic        if_flush [3];
    logic        d_req    [3];
    logic        d_we     [3];
    logic [31:0] d_addr   [3];
    logic [31:0] d_wdata  [3];
    logic [31:0] if_rdata [3];
    logic        if_valid [3];
    logic        if_stall [3];
    logic [31:0] d_rdata  [3];
    logic        d_valid  [3];
    logic        d_stall  [3];
    logic        mem_en   [3];
    logic        mem_we   [3];
    logic [31:0] mem_addr [3];
    logic [31:0] mem_wdata[3];

    rsp_t q_if[$];
    rsp_t q_d[$];
    acc_t q_mem[$];

    logic [31:0] exp_ifrd;
    logic [31:0] exp_drd;
    int          last_v[3];
    int          nval[3];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] rd(input logic [31:0] a);
        if (a == 32'h40) return 32'h8C22_0004;
        return {~a[15:0], a[15:0]} ^ 32'h1357_0000;
    endfunction

    for (genvar i = 0; i < 3; i++) begin : g
        localparam int L = (i == 0) ? 2 : ((i == 1) ? 1 : 15);
        imem_dmem_arbiter_if bus ();
        int          ret  = -100;
        logic [31:0] rdat = '0;
        logic [31:0] mrd  = '0;

        assign bus.if_req    = if_req[i];
        assign bus.if_addr   = if_addr[i];
        assign bus.if_flush  = if_flush[i];
        assign bus.d_req     = d_req[i];
        assign bus.d_we      = d_we[i];
        assign bus.d_addr    = d_addr[i];
        assign bus.d_wdata   = d_wdata[i];
        assign bus.mem_rdata = mrd;
        assign if_rdata[i]   = bus.if_rdata;
        assign if_valid[i]   = bus.if_valid;
        assign if_stall[i]   = bus.if_stall;
        assign d_rdata[i]    = bus.d_rdata;
        assign d_valid[i]    = bus.d_valid;
        assign d_stall[i]    = bus.d_stall;
        assign mem_en[i]     = bus.mem_en;
        assign mem_we[i]     = bus.mem_we;
        assign mem_addr[i]   = bus.mem_addr;
        assign mem_wdata[i]  = bus.mem_wdata;

        // Memory model: data valid only in the cycle L after the strobe.
        always @(negedge clk) begin
            if (bus.mem_en) begin
                ret  <= cyc + L;
                rdat <= rd(bus.mem_addr);
            end
            mrd <= (cyc == ret) ? rdat : 32'hBAD0_BAD0;
        end

        imem_dmem_arbiter #(.MEM_LAT(L), .STARVE_MAX(4)) dut (
            .clk (clk),
            .rst (i == 0 ? rst : rst_sw),
            .bus (bus)
        );
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %h want %h", name, cyc, act, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_mem_en"}, 32'(mem_en[0]), 32'h0);
        chk({tag, "_mem_we"}, 32'(mem_we[0]), 32'h0);
        chk({tag, "_mem_addr"}, mem_addr[0], 32'h0);
        chk({tag, "_mem_wdata"}, mem_wdata[0], 32'h0);
        chk({tag, "_if_rdata"}, if_rdata[0], 32'h0);
        chk({tag, "_if_valid"}, 32'(if_valid[0]), 32'h0);
        chk({tag, "_if_stall"}, 32'(if_stall[0]), 32'h0);
        chk({tag, "_d_rdata"}, d_rdata[0], 32'h0);
        chk({tag, "_d_valid"}, 32'(d_valid[0]), 32'h0);
        chk({tag, "_d_stall"}, 32'(d_stall[0]), 32'h0);
    endtask

    task automatic monitor();
        acc_t a;
        rsp_t r;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (mem_en[0]) begin
                    if (q_mem.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL mem_extra at cycle %0d: got access %h want none", cyc, mem_addr[0]);
                    end else begin
                        a = q_mem.pop_front();
                        chk("mem_addr", mem_addr[0], a.addr);
                        chk("mem_we", 32'(mem_we[0]), 32'(a.we));
                        if (a.we) chk("mem_wdata", mem_wdata[0], a.wdata);
                        chk("mem_cycle", 32'(cyc), 32'(a.cyc));
                    end
                end
                if (if_valid[0]) begin
                    if (q_if.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL if_extra at cycle %0d: got if_valid=1 want 0", cyc);
                    end else begin
                        r = q_if.pop_front();
                        chk("if_rdata", if_rdata[0], r.data);
                        chk("if_cycle", 32'(cyc), 32'(r.cyc));
                    end
                end
                if (d_valid[0]) begin
                    if (q_d.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL d_extra at cycle %0d: got d_valid=1 want 0", cyc);
                    end else begin
                        r = q_d.pop_front();
                        chk("d_rdata", d_rdata[0], r.data);
                        chk("d_cycle", 32'(cyc), 32'(r.cyc));
                    end
                end
                if (if_valid[0] || d_valid[0])
                    chk("valid_overlap", 32'(if_valid[0] & d_valid[0]), 32'h0);
                chk("if_stall", 32'(if_stall[0]), 32'(if_req[0] & ~if_valid[0]));
                chk("d_stall", 32'(d_stall[0]), 32'(d_req[0] & ~d_valid[0]));
            end
            if (rst_sw) begin
                for (int k = 1; k < 3; k++) begin
                    if (if_valid[k]) begin
                        chk("sweep_rdata", if_rdata[k], rd(SWA));
                        if (last_v[k] >= 0)
                            chk("sweep_period", 32'(cyc - last_v[k]), (k == 1) ? 32'd4 : 32'd18);
                        last_v[k] = cyc;
                        nval[k]++;
                    end
                end
            end
        end
    endtask

    task automatic wait_valid(input bit is_d, input int lim);
        bit got = 1'b0;
        for (int n = 0; n < lim && !got; n++) begin
            @(negedge clk);
            got = is_d ? d_valid[0] : if_valid[0];
        end
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL timeout at cycle %0d: got no valid want valid (d=%0d)", cyc, is_d);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [31:0] a);
        q_mem.push_back('{a, 1'b0, 32'h0, cyc + 1});
        q_if.push_back('{rd(a), cyc + 4});
        exp_ifrd = rd(a);
        if_req[0]  = 1'b1;
        if_addr[0] = a;
        wait_valid(1'b0, 20);
        if_req[0] = 1'b0;
    endtask

    task automatic dacc(input logic we, input logic [31:0] a, input logic [31:0] wd);
        q_mem.push_back('{a, we, wd, cyc + 1});
        if (!we) exp_drd = rd(a);
        q_d.push_back('{exp_drd, cyc + 4});
        d_req[0]   = 1'b1;
        d_we[0]    = we;
        d_addr[0]  = a;
        d_wdata[0] = wd;
        wait_valid(1'b1, 20);
        d_req[0] = 1'b0;
    endtask

    initial begin
        int t0;
        rst    = 1'b0;
        rst_sw = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if_req[k]   = (k != 0);
            if_addr[k]  = (k != 0) ? SWA : 32'h0;
            if_flush[k] = 1'b0;
            d_req[k]    = 1'b0;
            d_we[k]     = 1'b0;
            d_addr[k]   = 32'h0;
            d_wdata[k]  = 32'h0;
            last_v[k]   = -1;
            nval[k]     = 0;
        end
        exp_ifrd = 32'h0;
        exp_drd  = 32'h0;
        fork
            monitor();
        join_none

        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset");
        rst    = 1'b1;
        rst_sw = 1'b1;

        fetch(32'h40);

        t0 = cyc;
        for (int j = 0; j < 10; j++) begin
            if (j == 4 || j == 9) begin
                q_mem.push_back('{32'h200, 1'b0, 32'h0, t0 + 5 * j + 1});
                q_if.push_back('{rd(32'h200), t0 + 5 * j + 4});
            end else begin
                q_mem.push_back('{32'h300, 1'b0, 32'h0, t0 + 5 * j + 1});
                q_d.push_back('{rd(32'h300), t0 + 5 * j + 4});
            end
        end
        if_req[0]  = 1'b1;
        if_addr[0] = 32'h200;
        d_req[0]   = 1'b1;
        d_we[0]    = 1'b0;
        d_addr[0]  = 32'h300;
        repeat (50) @(posedge clk);
        #1;
        if_req[0] = 1'b0;
        d_req[0]  = 1'b0;
        exp_ifrd  = rd(32'h200);
        exp_drd   = rd(32'h300);

        dacc(1'b1, 32'h100, 32'hDEAD_BEEF);

        t0 = cyc;
        q_mem.push_back('{32'h80, 1'b0, 32'h0, t0 + 2});
        q_if.push_back('{rd(32'h80), t0 + 5});
        if_req[0]   = 1'b1;
        if_addr[0]  = 32'h80;
        if_flush[0] = 1'b1;
        @(posedge clk);
        #1;
        if_flush[0] = 1'b0;
        wait_valid(1'b0, 20);
        if_req[0] = 1'b0;
        exp_ifrd  = rd(32'h80);

        t0 = cyc;
        q_mem.push_back('{32'hC0, 1'b0, 32'h0, t0 + 1});
        q_mem.push_back('{32'hE0, 1'b0, 32'h0, t0 + 6});
        q_if.push_back('{rd(32'hE0), t0 + 9});
        if_req[0]  = 1'b1;
        if_addr[0] = 32'hC0;
        repeat (2) @(posedge clk);
        #1;
        if_flush[0] = 1'b1;
        if_addr[0]  = 32'hE0;
        @(posedge clk);
        #1;
        if_flush[0] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("flush_no_valid", 32'(if_valid[0]), 32'h0);
        @(negedge clk);
        chk("flush_rdata_hold", if_rdata[0], exp_ifrd);
        wait_valid(1'b0, 20);
        if_req[0] = 1'b0;
        exp_ifrd  = rd(32'hE0);

        t0 = cyc;
        q_mem.push_back('{32'h40, 1'b0, 32'h0, t0 + 1});
        if_req[0]  = 1'b1;
        if_addr[0] = 32'h40;
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk_zero("async_rst");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        q_mem.push_back('{32'h40, 1'b0, 32'h0, cyc + 1});
        q_if.push_back('{rd(32'h40), cyc + 4});
        exp_ifrd = rd(32'h40);
        exp_drd  = 32'h0;
        wait_valid(1'b0, 20);
        if_req[0] = 1'b0;

        dacc(1'b0, 32'h144, 32'h0);
        dacc(1'b1, 32'h148, 32'h1234_5678);

        while (cyc < 160) @(posedge clk);
        @(negedge clk);
        chk("left_mem", 32'(q_mem.size()), 32'h0);
        chk("left_if", 32'(q_if.size()), 32'h0);
        chk("left_d", 32'(q_d.size()), 32'h0);
        chk("sweep1_count", 32'(nval[1] >= 5), 32'h1);
        chk("sweep15_count", 32'(nval[2] >= 5), 32'h1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
